ssd_scan_ctrl: RTL and testbench

//   Time-multiplexes four BCD digits onto the shared 4-bit BCD/7-seg decoder path of the board.

---
 rtl/ssd_pkg.sv | 14 +
 rtl/scan_tick_gen.sv | 26 ++
 rtl/ssd_scan_ctrl.sv | 84 ++++++++
 tb/tb_ssd_scan_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package ssd_pkg;

    localparam logic [3:0] SSD_DIGIT_OFF    = 4'b1111;
    localparam int         SSD_NDIG         = 4;
    localparam int         SSD_IDX_W        = $clog2(SSD_NDIG);
    localparam int         SCAN_DIV_DEFAULT = 100000;

    // One-hot-low enable mask for digit position idx.
    function automatic logic [3:0] ssd_digit_mask(input logic [SSD_IDX_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler for the digit scan: one-cycle tick every DIV enabled clocks.
module scan_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] presc;

    assign tick = en && (presc == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit BCD scan multiplexer with per-frame capture and leading-zero blanking.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  bin_out,
    output logic        dp_out,
    output logic [3:0]  d
);

    logic                 tick;
    logic                 wrap;
    logic                 was_off;
    logic                 blank;
    logic [SSD_IDX_W-1:0] idx;
    logic [SSD_IDX_W-1:0] idx_next;
    logic [SSD_IDX_W-1:0] sel_idx;
    logic [15:0]          snap;
    logic [15:0]          frame;
    logic [3:0]           snap_dp;
    logic [3:0]           frame_dp;
    logic [3:0]           lz;
    logic [3:0]           digit;

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .tick (tick)
    );

    // On a wrap tick the frame being captured is displayed immediately.
    always_comb begin
        idx_next = idx + 1'b1;
        wrap     = tick && (idx == SSD_IDX_W'(SSD_NDIG - 1));
        frame    = wrap ? bcd_in : snap;
        frame_dp = wrap ? dp_in : snap_dp;
        sel_idx  = tick ? idx_next : idx;
        digit    = frame[{sel_idx, 2'b00} +: 4];
        lz[3]    = (frame[15:12] == 4'h0);
        lz[2]    = lz[3] && (frame[11:8] == 4'h0);
        lz[1]    = lz[2] && (frame[7:4] == 4'h0);
        lz[0]    = 1'b0;
        blank    = blank_lz && lz[sel_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= SSD_IDX_W'(SSD_NDIG - 1);
            snap    <= '0;
            snap_dp <= '0;
            bin_out <= '0;
            dp_out  <= 1'b0;
            d       <= SSD_DIGIT_OFF;
            was_off <= 1'b0;
        end else if (!en) begin
            d       <= SSD_DIGIT_OFF;
            dp_out  <= 1'b0;
            was_off <= 1'b1;
        end else begin
            was_off <= 1'b0;
            if (tick) begin
                idx     <= idx_next;
                bin_out <= digit;
                if (wrap) begin
                    snap    <= bcd_in;
                    snap_dp <= dp_in;
                end
            end
            if (tick || was_off) begin
                d      <= blank ? SSD_DIGIT_OFF : ssd_digit_mask(sel_idx);
                dp_out <= frame_dp[sel_idx] && !blank;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized self-checking bench for ssd_scan_ctrl against a frame-level display model.
module tb_ssd_scan_ctrl;

    localparam int DIV = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        en       = 1'b0;
    logic [15:0] bcd_in   = '0;
    logic [3:0]  dp_in    = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bin_out;
    logic        dp_out;
    logic [3:0]  d;

    int checks = 0;
    int errors = 0;

    ssd_scan_ctrl #(.SCAN_DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .bcd_in  (bcd_in),
        .dp_in   (dp_in),
        .blank_lz(blank_lz),
        .bin_out (bin_out),
        .dp_out  (dp_out),
        .d       (d)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] presc;
        logic [1:0]  idx;
        logic [15:0] snap;
        logic [3:0]  snap_dp;
        logic [3:0]  d;
        logic [3:0]  bin;
        logic        dp;
        logic        off;
    } mstate_t;

    localparam mstate_t M_RESET = '{presc: 0, idx: 2'd3, snap: 16'h0, snap_dp: 4'h0,
                                    d: 4'hF, bin: 4'h0, dp: 1'b0, off: 1'b0};

    mstate_t m = M_RESET;

    // Digit k is blank when it and every digit to its left are zero.
    function automatic logic is_blank(int k, logic [15:0] f, logic blz);
        return blz && (k != 0) && ((f >> (4 * k)) == 16'h0);
    endfunction

    function automatic mstate_t model_step(mstate_t s, logic en_i, logic [15:0] b,
                                           logic [3:0] p, logic blz);
        mstate_t n = s;
        int k;
        logic bl;
        if (!en_i) begin
            n.d = 4'hF;
            n.dp = 1'b0;
            n.off = 1'b1;
            return n;
        end
        n.off = 1'b0;
        if (s.presc == DIV - 1) begin
            n.presc = 0;
            if (s.idx == 2'd3) begin
                n.snap = b;
                n.snap_dp = p;
            end
            k = (int'(s.idx) + 1) % 4;
            n.idx = 2'(k);
            n.bin = 4'((n.snap >> (4 * k)) & 16'hF);
        end else begin
            n.presc = s.presc + 1;
            k = int'(s.idx);
            if (!s.off) return n;
        end
        bl = is_blank(k, n.snap, blz);
        n.d = bl ? 4'hF : 4'(15 - (1 << k));
        n.dp = n.snap_dp[k] && !bl;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= M_RESET;
        else m <= model_step(m, en, bcd_in, dp_in, blank_lz);
    end

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({d, bin_out, dp_out} !== {4'hF, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset: d/bin/dp got %b/%h/%b want 1111/0/0", d, bin_out, dp_out);
        end
        en = 1'b1;
        bcd_in = 16'h1234;
        rst_n = 1'b1;
    endtask

    task automatic test_scan_order(input string tag);
        logic [3:0] td[5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        logic [3:0] tb[5] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h4};
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            checks++;
            if ({d, bin_out, dp_out} !== {m.d, m.bin, m.dp}) begin
                errors++;
                $display("FAIL %s model edge %0d: got %b/%h/%b want %b/%h/%b",
                         tag, e, d, bin_out, dp_out, m.d, m.bin, m.dp);
            end
            checks++;
            if (e % 4 == 0) begin
                if ({d, bin_out} !== {td[e/4-1], tb[e/4-1]}) begin
                    errors++;
                    $display("FAIL %s slot edge %0d: got %b/%h want %b/%h",
                             tag, e, d, bin_out, td[e/4-1], tb[e/4-1]);
                end
            end else if (e < 4 && d !== 4'hF) begin
                errors++;
                $display("FAIL %s dark edge %0d: got d=%b want 1111", tag, e, d);
            end else if (e > 4 && d !== td[e/4-1]) begin
                errors++;
                $display("FAIL %s hold edge %0d: got d=%b want %b", tag, e, d, td[e/4-1]);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [3:0] tb[4] = '{4'h2, 4'h1, 4'h8, 4'h7};
        repeat (4) @(negedge clk);
        bcd_in = 16'h5678;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if ({d, bin_out, dp_out} !== {m.d, m.bin, m.dp}) begin
                errors++;
                $display("FAIL snapshot model %0d: got %b/%h/%b want %b/%h/%b",
                         i, d, bin_out, dp_out, m.d, m.bin, m.dp);
            end
            if (i % 4 == 0) begin
                checks++;
                if (bin_out !== tb[i/4-1]) begin
                    errors++;
                    $display("FAIL snapshot slot %0d: got bin=%h want %h", i, bin_out, tb[i/4-1]);
                end
            end
        end
    endtask

    task automatic test_blank();
        logic [15:0] pats[3] = '{16'h0007, 16'h0000, 16'h0105};
        blank_lz = 1'b1;
        for (int p = 0; p < 3; p++) begin
            bcd_in = pats[p];
            for (int i = 1; i <= 32; i++) begin
                @(negedge clk);
                checks++;
                if ({d, bin_out, dp_out} !== {m.d, m.bin, m.dp}) begin
                    errors++;
                    $display("FAIL blank %h edge %0d: got %b/%h/%b want %b/%h/%b",
                             pats[p], i, d, bin_out, dp_out, m.d, m.bin, m.dp);
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_enable();
        logic [3:0] saved_d;
        bit found = 0;
        bcd_in = 16'h4321;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (m.presc == 0 && m.d != 4'hF) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL enable: no tick seen within 8 cycles (want one)");
        end
        saved_d = m.d;
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({d, dp_out} !== {4'hF, 1'b0}) begin
            errors++;
            $display("FAIL enable dark: got d=%b dp=%b want 1111/0", d, dp_out);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({d, bin_out, dp_out} !== {m.d, m.bin, m.dp}) begin
                errors++;
                $display("FAIL enable frozen %0d: got %b/%h/%b want %b/%h/%b",
                         i, d, bin_out, dp_out, m.d, m.bin, m.dp);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (i < 3 && d !== saved_d) begin
                errors++;
                $display("FAIL enable relit %0d: got d=%b want %b", i, d, saved_d);
            end else if (i == 3 && (d === saved_d || d !== m.d)) begin
                errors++;
                $display("FAIL enable resume: got d=%b want %b (not %b)", d, m.d, saved_d);
            end
        end
    endtask

    task automatic test_dp();
        bcd_in = 16'h9876;
        dp_in = 4'b0100;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            checks++;
            if ({d, bin_out, dp_out} !== {m.d, m.bin, m.dp}) begin
                errors++;
                $display("FAIL dp model %0d: got %b/%h/%b want %b/%h/%b",
                         i, d, bin_out, dp_out, m.d, m.bin, m.dp);
            end
            if (i > 16) begin
                checks++;
                if (dp_out !== (d == 4'b1011)) begin
                    errors++;
                    $display("FAIL dp slot %0d: got dp=%b with d=%b want dp only in digit 2",
                             i, dp_out, d);
                end
            end
        end
        bcd_in = 16'h0000;
        blank_lz = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i > 16) begin
                checks++;
                if (dp_out !== 1'b0) begin
                    errors++;
                    $display("FAIL dp blanked %0d: got dp=%b want 0", i, dp_out);
                end
            end
        end
        blank_lz = 1'b0;
        dp_in = 4'b0000;
    endtask

    task automatic test_async_reset();
        bcd_in = 16'h1234;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({d, bin_out, dp_out} !== {4'hF, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL async reset: got %b/%h/%b want 1111/0/0", d, bin_out, dp_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_scan_order("rescan");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if ({d, bin_out, dp_out} !== {m.d, m.bin, m.dp}) begin
                errors++;
                $display("FAIL random %0d: got %b/%h/%b want %b/%h/%b",
                         i, d, bin_out, dp_out, m.d, m.bin, m.dp);
            end
            if ($urandom_range(7) == 0) begin
                bcd_in = 16'($urandom);
                if ($urandom_range(1) == 0) bcd_in[15:8] = 8'h00;
            end
            if ($urandom_range(7) == 0) dp_in = 4'($urandom);
            if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(19) == 0) en = ~en;
        end
    endtask

    initial begin
        test_reset();
        test_scan_order("scan");
        test_snapshot();
        test_blank();
        test_enable();
        test_dp();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
